// File: rtl/in_pass4_sync_filter_pkg.sv
// rtl/in_pass4_sync_filter_pkg.sv - shared mode encodings and sizes for the input pass filter
package in_pass4_sync_filter_pkg;

    // Per-bit conditioning mode, taken from a 2-bit slice of the frame config.
    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_REG    = 2'b01;
    localparam logic [1:0] MODE_SYNC   = 2'b10;
    localparam logic [1:0] MODE_FILT   = 2'b11;

    localparam int NUM_BITS = 4;
    localparam int MODE_W   = 2;

endpackage

// File: rtl/cus_mux21.sv
// rtl/cus_mux21.sv - custom 2:1 mux cell shared by the pass BELs
//
// Ports:
//   i_a0 - data input selected when i_s = 0
//   i_a1 - data input selected when i_s = 1
//   i_s  - select
//   o_x  - mux output
module cus_mux21 (
    input  logic i_a0,
    input  logic i_a1,
    input  logic i_s,
    output logic o_x
);

    assign o_x = i_s ? i_a1 : i_a0;

endmodule

// File: rtl/in_pass_bit_filter.sv
// rtl/in_pass_bit_filter.sv - one input bit: bypass/register/synchronizer/debounce plus rising-edge pulse
//
// Ports:
//   i_clk  - fabric user clock
//   i_rst  - asynchronous active-high reset
//   i_pad  - external pad input
//   i_mode - conditioning mode (see package MODE_*)
//   o_o    - conditioned signal
//   o_r    - one-cycle pulse on each 0->1 transition of the selected registered value
module in_pass_bit_filter
    import in_pass4_sync_filter_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pad,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_o,
    output logic              o_r
);

    generate
        if (FILTER_LEN < 2 || FILTER_LEN > 16 || (2 ** CNT_W) < FILTER_LEN) begin : g_bad_param
            $error("in_pass_bit_filter: FILTER_LEN must be 2..16 and fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_f;
    logic             r_p;
    logic [CNT_W-1:0] r_cnt;

    logic w_o_lo;
    logic w_hi;
    logic w_sel_lo;
    logic w_sel;

    // All state advances every cycle; the mode only steers the outputs, so a
    // runtime mode change sees already-settled synchronizer/filter state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_f   <= 1'b0;
            r_p   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
            r_p  <= w_sel;
            // Counter tracks consecutive cycles where s2 disagrees with f;
            // any agreement (a glitch back) restarts the count from zero.
            if (r_s2 == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_f   <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output 4:1 built from 2:1 cells: mode[0] picks within a pair, mode[1] picks the pair.
    cus_mux21 u_o_lo (.i_a0(i_pad), .i_a1(r_s1), .i_s(i_mode[0]), .o_x(w_o_lo));
    cus_mux21 u_hi   (.i_a0(r_s2),  .i_a1(r_f),  .i_s(i_mode[0]), .o_x(w_hi));
    cus_mux21 u_o    (.i_a0(w_o_lo), .i_a1(w_hi), .i_s(i_mode[1]), .o_x(o_o));

    // Edge-detect select: same tree, but bypass contributes 0 so the
    // unregistered pad never produces pulses. Upper pair is shared.
    cus_mux21 u_sel_lo (.i_a0(1'b0), .i_a1(r_s1), .i_s(i_mode[0]), .o_x(w_sel_lo));
    cus_mux21 u_sel    (.i_a0(w_sel_lo), .i_a1(w_hi), .i_s(i_mode[1]), .o_x(w_sel));

    assign o_r = w_sel & ~r_p;

endmodule

// File: rtl/in_pass4_sync_filter.sv
// rtl/in_pass4_sync_filter.sv - 4-bit configurable input pass BEL with sync/debounce and edge pulses
//
// Ports:
//   UserCLK    - fabric user clock
//   Reset      - asynchronous active-high reset
//   I          - external pad inputs
//   O          - conditioned signals to the switch matrix
//   R          - rising-edge pulses of each bit's selected conditioned value
//   ConfigBits - frame config; mode of bit i is ConfigBits[2i+1:2i]
module in_pass4_sync_filter
    import in_pass4_sync_filter_pkg::*;
#(
    parameter int NoConfigBits = 8,
    parameter int FILTER_LEN   = 4,
    parameter int CNT_W        = 4
) (
    input  logic                    UserCLK,
    input  logic                    Reset,
    input  logic [NUM_BITS-1:0]     I,
    output logic [NUM_BITS-1:0]     O,
    output logic [NUM_BITS-1:0]     R,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
            in_pass_bit_filter #(
                .FILTER_LEN(FILTER_LEN),
                .CNT_W     (CNT_W)
            ) u_bit (
                .i_clk (UserCLK),
                .i_rst (Reset),
                .i_pad (I[gi]),
                .i_mode(ConfigBits[MODE_W*gi +: MODE_W]),
                .o_o   (O[gi]),
                .o_r   (R[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_in_pass4_sync_filter.sv
// tb/tb_in_pass4_sync_filter.sv - self-checking bench for in_pass4_sync_filter
module tb_in_pass4_sync_filter;
    import in_pass4_sync_filter_pkg::*;

    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] I;
    logic [7:0] cfg;
    logic [3:0] O;
    logic [3:0] R;

    int n_vec = 0;
    int n_bad = 0;

    in_pass4_sync_filter #(.NoConfigBits(8), .FILTER_LEN(FL), .CNT_W(4)) dut (
        .UserCLK   (clk),
        .Reset     (rst),
        .I         (I),
        .O         (O),
        .R         (R),
        .ConfigBits(cfg)
    );

    always #5 clk = ~clk;

    // Reference model: s1/s2 are the pad delayed by one/two cycles; the
    // filtered level flips once the last FL synchronized samples all disagree with it.
    logic          m_s1 [4];
    logic          m_s2 [4];
    logic          m_f  [4];
    logic          m_p  [4];
    logic [FL-1:0] m_win[4];

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_f[b] = 1'b0; m_p[b] = 1'b0; m_win[b] = '0;
        end
    endtask

    function automatic logic model_sel(input int b);
        logic [1:0] md;
        md = cfg[2*b +: 2];
        case (md)
            MODE_BYPASS: return 1'b0;
            MODE_REG:    return m_s1[b];
            MODE_SYNC:   return m_s2[b];
            default:     return m_f[b];
        endcase
    endfunction

    task automatic model_out(output logic [3:0] mo, output logic [3:0] mr);
        mo = '0; mr = '0;
        for (int b = 0; b < 4; b++) begin
            mo[b] = (cfg[2*b +: 2] == MODE_BYPASS) ? I[b] : model_sel(b);
            mr[b] = model_sel(b) & ~m_p[b];
        end
    endtask

    task automatic model_edge();
        logic sel_old;
        if (rst) begin
            model_reset();
        end else begin
            for (int b = 0; b < 4; b++) begin
                sel_old  = model_sel(b);
                m_p[b]   = sel_old;
                m_win[b] = {m_win[b][FL-2:0], m_s2[b]};
                if (m_win[b] == {FL{~m_f[b]}}) m_f[b] = ~m_f[b];
                m_s2[b]  = m_s1[b];
                m_s1[b]  = I[b];
            end
        end
    endtask

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive on the falling edge, compare mid-low-phase, advance model at the rising edge.
    task automatic step(input logic rv, input logic [7:0] cv, input logic [3:0] iv,
                        input logic [3:0] mask, input logic [3:0] eo, input logic [3:0] er,
                        input string tag);
        logic [3:0] mo, mr;
        @(negedge clk);
        rst = rv; cfg = cv; I = iv;
        if (rv) model_reset();
        #1;
        model_out(mo, mr);
        check({tag, " O vs model"}, O, mo);
        check({tag, " R vs model"}, R, mr);
        if (mask != 4'b0000) begin
            check({tag, " O"}, O & mask, eo & mask);
            check({tag, " R"}, R & mask, er & mask);
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic clean(input logic [7:0] cv);
        step(1'b1, cv, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "clean");
        step(1'b1, cv, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "clean");
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] cfg;
        logic [3:0] i;
        logic [3:0] exp_o;
        logic [3:0] exp_r;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [3:0] lvl;
        logic [7:0] rc;
        logic       rr;
        logic [7:0] c_lat, c_flt;

        rst = 1'b1; I = 4'b0000; cfg = 8'h00;
        model_reset();

        tbl[0] = '{1'b1, 8'b11_10_01_01, 4'b1111, 4'b0000, 4'b0000};
        tbl[1] = '{1'b1, 8'b11_10_01_00, 4'b1111, 4'b0001, 4'b0000};
        tbl[2] = '{1'b1, 8'b11_10_01_00, 4'b1110, 4'b0000, 4'b0000};
        tbl[3] = '{1'b1, 8'b00_00_00_00, 4'b1010, 4'b1010, 4'b0000};
        tbl[4] = '{1'b1, 8'b11_11_11_11, 4'b1111, 4'b0000, 4'b0000};
        tbl[5] = '{1'b1, 8'b00_11_00_11, 4'b1010, 4'b1010, 4'b0000};
        for (int k = 0; k < 6; k++)
            step(tbl[k].rst, tbl[k].cfg, tbl[k].i, 4'b1111, tbl[k].exp_o, tbl[k].exp_r, "reset table");

        // Latency: bit1 registered, bit2 synchronized.
        c_lat = {MODE_BYPASS, MODE_SYNC, MODE_REG, MODE_BYPASS};
        clean(c_lat);
        step(1'b0, c_lat, 4'b0110, 4'b0110, 4'b0000, 4'b0000, "lat c0");
        step(1'b0, c_lat, 4'b0110, 4'b0110, 4'b0010, 4'b0010, "lat c1");
        step(1'b0, c_lat, 4'b0110, 4'b0110, 4'b0110, 4'b0100, "lat c2");
        step(1'b0, c_lat, 4'b0110, 4'b0110, 4'b0110, 4'b0000, "lat c3");

        c_flt = {MODE_FILT, MODE_BYPASS, MODE_BYPASS, MODE_BYPASS};

        // 3-cycle pulse is rejected.
        clean(c_flt);
        for (int k = 0; k < 11; k++)
            step(1'b0, c_flt, (k < 3) ? 4'b1000 : 4'b0000, 4'b1000, 4'b0000, 4'b0000, "glitch3");

        // Steady high then steady low.
        clean(c_flt);
        for (int k = 0; k < 10; k++)
            step(1'b0, c_flt, 4'b1000, 4'b1000, (k >= 6) ? 4'b1000 : 4'b0000,
                 (k == 6) ? 4'b1000 : 4'b0000, "filt rise");
        for (int k = 0; k < 10; k++)
            step(1'b0, c_flt, 4'b0000, 4'b1000, (k < 6) ? 4'b1000 : 4'b0000, 4'b0000, "filt fall");

        // Glitch restarts the count.
        clean(c_flt);
        step(1'b0, c_flt, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "restart pre");
        step(1'b0, c_flt, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "restart pre");
        step(1'b0, c_flt, 4'b0000, 4'b1000, 4'b0000, 4'b0000, "restart pre");
        for (int k = 0; k < 10; k++)
            step(1'b0, c_flt, 4'b1000, 4'b1000, (k >= 6) ? 4'b1000 : 4'b0000,
                 (k == 6) ? 4'b1000 : 4'b0000, "restart");

        // Reset mid-filter discards the partial count.
        clean(c_flt);
        for (int k = 0; k < 3; k++)
            step(1'b0, c_flt, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "midrst pre");
        step(1'b1, c_flt, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "midrst in");
        step(1'b1, c_flt, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "midrst in");
        for (int k = 0; k < 10; k++)
            step(1'b0, c_flt, 4'b1000, 4'b1000, (k >= 6) ? 4'b1000 : 4'b0000,
                 (k == 6) ? 4'b1000 : 4'b0000, "midrst post");

        // Runtime mode switch on bit1: bypass -> sync -> bypass.
        clean(8'h00);
        for (int k = 0; k < 4; k++)
            step(1'b0, 8'h00, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "msw byp");
        step(1'b0, {6'b0, MODE_SYNC, 2'b00} , 4'b0010, 4'b0010, 4'b0010, 4'b0010, "msw sync");
        step(1'b0, {4'b0, MODE_SYNC, 2'b00}, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "msw hold");
        step(1'b0, 8'h00, 4'b0010, 4'b0010, 4'b0010, 4'b0000, "msw back");

        // Randomized run against the model; levels change slowly so filters can pass.
        clean(8'h00);
        lvl = 4'b0000;
        rc  = 8'hFF;
        for (int k = 0; k < 500; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
            if ($urandom_range(0, 19) == 0) rc = 8'($urandom);
            rr = ($urandom_range(0, 59) == 0);
            step(rr, rc, lvl, 4'b0000, 4'b0000, 4'b0000, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
